keypad_scanner: RTL and testbench

//   Parametrised matrix-keypad scanner. Drives an active-low one-cold row ring at a

---
 rtl/keypad_scanner.sv | 186 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Matrix-keypad scanner: one-cold row ring, synchronised columns, press/release debounce, key encoding.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
    parameter int  ROWS         = 4,
    parameter int  COLS         = 4,
    parameter int  SCAN_DIV     = 1000,
    parameter int  DEBOUNCE     = 4,
    parameter int  REPEAT_TICKS = 250,
    localparam int CW           = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [COLS-1:0] col,
    output logic [ROWS-1:0] row,
    output logic [CW-1:0]   key_code,
    output logic            key_valid,
    output logic            key_held
);
    localparam int RW  = $clog2(ROWS);
    localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW  = $clog2(SCAN_DIV);
    localparam int DW  = $clog2(DEBOUNCE + 1);
    localparam logic [SW-1:0]   CNT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0]   DEB_DONE = DW'(DEBOUNCE);
    localparam logic [ROWS-1:0] ROW_RST  = {{(ROWS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {S_SCAN, S_DEB, S_HELD} state_t;

    state_t          state_q, state_d;
    logic [COLS-1:0] col_meta_q, col_sync_q;
    logic [SW-1:0]   cnt_q;
    logic [ROWS-1:0] row_q, row_d, row_next;
    logic [RW-1:0]   cand_row_q, cand_row_d, row_idx;
    logic [CLW-1:0]  cand_col_q, cand_col_d, low_col;
    logic [DW-1:0]   deb_cnt_q, deb_cnt_d, rel_cnt_q, rel_cnt_d;
    logic [CW-1:0]   key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d, key_held_q, key_held_d;
    logic            tick, row_ok, any_low, accept;
    int              row_zeros;
`ifdef KEYPAD_REPEAT_EN
    localparam int RPW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
    localparam logic [RPW-1:0] REP_LAST = RPW'(REPEAT_TICKS - 1);
    logic [RPW-1:0] rep_cnt_q, rep_cnt_d;
`endif

    assign tick    = enable && (cnt_q == CNT_LAST);
    assign any_low = ~&col_sync_q;

    // Row index of the driven row, plus a sanity check that exactly one row is low.
    always_comb begin
        row_idx   = '0;
        row_zeros = 0;
        for (int i = 0; i < ROWS; i++) begin
            if (!row_q[i]) begin
                row_idx = RW'(i);
                row_zeros++;
            end
        end
        row_ok = (row_zeros == 1);
    end

    always_comb begin
        low_col = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (!col_sync_q[i]) low_col = CLW'(i);
        end
    end

    assign row_next = row_ok ? {row_q[ROWS-2:0], row_q[ROWS-1]} : ROW_RST;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        cand_row_d  = cand_row_q;
        cand_col_d  = cand_col_q;
        deb_cnt_d   = deb_cnt_q;
        rel_cnt_d   = rel_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        accept      = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
`endif
        if (tick) begin
            if (!row_ok) begin
                row_d      = ROW_RST;
                state_d    = S_SCAN;
                key_held_d = 1'b0;
            end else begin
                case (state_q)
                    S_SCAN: begin
                        if (any_low) begin
                            cand_row_d = row_idx;
                            cand_col_d = low_col;
                            deb_cnt_d  = DW'(1);
                            if (DEBOUNCE == 1) accept = 1'b1;
                            else               state_d = S_DEB;
                        end else begin
                            row_d = row_next;
                        end
                    end
                    S_DEB: begin
                        if (!col_sync_q[cand_col_q]) begin
                            deb_cnt_d = deb_cnt_q + 1'b1;
                            if (deb_cnt_d == DEB_DONE) accept = 1'b1;
                        end else begin
                            state_d = S_SCAN;
                            row_d   = row_next;
                        end
                    end
                    S_HELD: begin
                        rel_cnt_d = col_sync_q[cand_col_q] ? rel_cnt_q + 1'b1 : '0;
                        if (rel_cnt_d == DEB_DONE) begin
                            key_held_d = 1'b0;
                            state_d    = S_SCAN;
                            row_d      = row_next;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt_d  = '0;
                        end else if (rep_cnt_q == REP_LAST) begin
                            rep_cnt_d   = '0;
                            key_valid_d = 1'b1;
                        end else begin
                            rep_cnt_d = rep_cnt_q + 1'b1;
`endif
                        end
                    end
                    default: state_d = S_SCAN;
                endcase
            end
        end
        // Accept may come straight from SCAN when a single tick of debounce suffices.
        if (accept) begin
            key_code_d  = CW'(int'(cand_row_d) * COLS + int'(cand_col_d));
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            rel_cnt_d   = '0;
            state_d     = S_HELD;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_d   = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_meta_q  <= '1;
            col_sync_q  <= '1;
            cnt_q       <= '0;
            state_q     <= S_SCAN;
            row_q       <= ROW_RST;
            cand_row_q  <= '0;
            cand_col_q  <= '0;
            deb_cnt_q   <= '0;
            rel_cnt_q   <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= '0;
`endif
        end else begin
            col_meta_q  <= col;
            col_sync_q  <= col_meta_q;
            if (enable) cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            state_q     <= state_d;
            row_q       <= row_d;
            cand_row_q  <= cand_row_d;
            cand_col_q  <= cand_col_d;
            deb_cnt_q   <= deb_cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
`endif
        end
    end

    assign row       = row_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives the columns from the DUT rows; a
// behavioural reference predicts row, key_code, key_valid and key_held every cycle.
module tb_keypad_scanner;
    localparam int ROWS = 4, COLS = 4, SCAN_DIV = 4, DEBOUNCE = 3, REPEAT_TICKS = 5;
    localparam int CW = 4;
    localparam int M_SCAN = 0, M_DEB = 1, M_HELD = 2;

    logic            clk = 1'b0;
    logic            reset, enable;
    logic [COLS-1:0] col;
    logic [ROWS-1:0] row;
    logic [CW-1:0]   key_code;
    logic            key_valid, key_held;

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE), .REPEAT_TICKS(REPEAT_TICKS)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .col(col),
        .row(row), .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    int n_assert = 0, n_fail = 0;
    int dut_pulses = 0, mdl_pulses = 0;
    logic [ROWS*COLS-1:0] pressed;

    // reference state
    int m_row, m_cnt, m_mode, m_cr, m_cc, m_deb, m_rel, m_rep, m_code;
    bit m_valid, m_held;
    logic [COLS-1:0] m_s1, m_s2;

    function automatic logic [COLS-1:0] keypad(input logic [ROWS-1:0] r, input logic [ROWS*COLS-1:0] k);
        logic [COLS-1:0] c = '1;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                if (r[i] === 1'b0 && k[i*COLS+j]) c[j] = 1'b0;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_row = 0; m_cnt = 0; m_mode = M_SCAN;
        m_cr = 0; m_cc = 0; m_deb = 0; m_rel = 0; m_rep = 0;
        m_code = 0; m_valid = 0; m_held = 0;
        m_s1 = '1; m_s2 = '1;
    endtask

    task automatic model_accept();
        m_code  = m_cr * COLS + m_cc;
        m_valid = 1;
        m_held  = 1;
        m_mode  = M_HELD;
        m_rel   = 0;
        m_rep   = 0;
    endtask

    task automatic model_edge();
        logic [COLS-1:0] s;
        bit tk;
        if (!reset) begin
            model_reset();
            return;
        end
        s = m_s2;
        m_valid = 0;
        tk = enable && (m_cnt == SCAN_DIV - 1);
        if (enable) m_cnt = (m_cnt + 1) % SCAN_DIV;
        if (tk) begin
            if (m_mode == M_SCAN) begin
                if (s != '1) begin
                    m_cr = m_row;
                    for (int j = COLS - 1; j >= 0; j--) if (!s[j]) m_cc = j;
                    m_deb = 1;
                    if (m_deb >= DEBOUNCE) model_accept();
                    else m_mode = M_DEB;
                end else m_row = (m_row + 1) % ROWS;
            end else if (m_mode == M_DEB) begin
                if (!s[m_cc]) begin
                    m_deb++;
                    if (m_deb >= DEBOUNCE) model_accept();
                end else begin
                    m_mode = M_SCAN;
                    m_row = (m_row + 1) % ROWS;
                end
            end else begin
                m_rel = s[m_cc] ? m_rel + 1 : 0;
                if (m_rel >= DEBOUNCE) begin
                    m_held = 0;
                    m_mode = M_SCAN;
                    m_row = (m_row + 1) % ROWS;
                end else begin
`ifdef KEYPAD_REPEAT_EN
                    m_rep++;
                    if (m_rep == REPEAT_TICKS) begin
                        m_valid = 1;
                        m_rep = 0;
                    end
`endif
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = col;
        if (m_valid) mdl_pulses++;
    endtask

    task automatic check_all(input string where);
        logic [ROWS-1:0] er = '1;
        er[m_row] = 1'b0;
        chk({where, ".row"}, row, er);
        chk({where, ".key_code"}, key_code, m_code);
        chk({where, ".key_valid"}, key_valid, m_valid);
        chk({where, ".key_held"}, key_held, m_held);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all("cyc");
        if (key_valid === 1'b1) dut_pulses++;
        col = keypad(row, pressed);
    endtask

    task automatic set_keys(input logic [ROWS*COLS-1:0] m);
        pressed = m;
        col = keypad(row, pressed);
    endtask

    initial begin
        int p, q, r;
        logic [ROWS*COLS-1:0] mask;
        reset = 1'b1; enable = 1'b1; pressed = '0; col = '1;
        model_reset();
        #2 reset = 1'b0;
        #1 check_all("reset");
        repeat (3) step();
        @(negedge clk) reset = 1'b1;

        // idle rotation, no keys
        repeat (24) step();
        chk("idle_no_pulse", dut_pulses, 0);

        // key 6 (row 1, col 2)
        set_keys(16'h0040);
        for (int i = 0; i < 200 && !m_held; i++) step();
        chk("k6_valid", key_valid, 1);
        chk("k6_held", key_held, 1);
        chk("k6_code", key_code, 6);
        chk("k6_row", row, 4'b1101);
        repeat (12) step();
        chk("k6_row_frozen", row, 4'b1101);
        set_keys('0);
        for (int i = 0; i < 200 && m_held; i++) step();
        chk("rel_held", key_held, 0);
        chk("rel_row", row, 4'b1011);

        // one-tick glitch on key 0
        for (int i = 0; i < 100 && !(m_row == 0 && m_cnt == 0 && m_mode == M_SCAN); i++) step();
        p = dut_pulses;
        set_keys(16'h0001);
        repeat (4) step();
        chk("gl_frozen", row, 4'b1110);
        set_keys('0);
        repeat (4) step();
        chk("gl_row", row, 4'b1101);
        chk("gl_nopulse", dut_pulses - p, 0);

        // enable low while debouncing
        set_keys(16'h0040);
        for (int i = 0; i < 100 && m_mode != M_DEB; i++) step();
        enable = 1'b0;
        repeat (20) step();
        chk("en_row", row, 4'b1101);
        chk("en_held", key_held, 0);
        enable = 1'b1;
        for (int i = 0; i < 100 && !m_held; i++) step();
        chk("en_done_held", key_held, 1);
        chk("en_done_code", key_code, 6);
        set_keys('0);
        for (int i = 0; i < 200 && m_held; i++) step();

        // randomized key activity
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 7);
            if (r == 0)      mask = '0;
            else if (r == 1) mask = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            else             mask = 16'h1 << $urandom_range(0, 15);
            set_keys(mask);
            enable = ($urandom_range(0, 5) != 0);
            repeat ($urandom_range(1, 60)) step();
            enable = 1'b1;
        end
        set_keys('0);
        for (int i = 0; i < 300 && m_mode != M_SCAN; i++) step();

        // long hold on key 15
        p = dut_pulses; q = mdl_pulses;
        set_keys(16'h8000);
        for (int i = 0; i < 200 && !m_held; i++) step();
        chk("k15_code", key_code, 15);
        repeat (200) step();
        set_keys('0);
        for (int i = 0; i < 200 && m_held; i++) step();
`ifdef KEYPAD_REPEAT_EN
        chk("k15_pulses", dut_pulses - p, mdl_pulses - q);
        chk("k15_multi", (dut_pulses - p) >= 2, 1);
`else
        chk("k15_single", dut_pulses - p, 1);
`endif

        // asynchronous reset while a key is held
        set_keys(16'h0200);
        for (int i = 0; i < 200 && !m_held; i++) step();
        chk("k9_code", key_code, 9);
        repeat (5) step();
        #2 reset = 1'b0;
        model_reset();
        #1;
        check_all("arst");
        chk("arst_row", row, 4'b1110);
        chk("arst_held", key_held, 0);
        chk("arst_code", key_code, 0);
        repeat (3) step();
        set_keys('0);
        @(negedge clk) reset = 1'b1;
        repeat (30) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
